// File: rtl/dual_edge_counter.sv
// Counts rising edges of sig_a and falling edges of sig_b up to LIMIT, and offers
// every new count downstream through a valid/ready snapshot register.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | not counting; waits for en
// ST_RUN  | counting events; leaves on en=0 or on reaching LIMIT
// ST_DONE | LIMIT reached; events ignored until clear
module dual_edge_counter #(
  parameter int WIDTH = 5,
  parameter int LIMIT = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic             sig_a,
  input  logic             sig_b,
  input  logic             out_ready,
  output logic [WIDTH-1:0] count,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             done,
  output logic             overrun
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

  state_t           state;
  state_t           state_next;
  logic             a_d;
  logic             b_d;
  logic             rise_a;
  logic             fall_b;
  logic             evt;
  logic             inc;
  logic             hit;
  logic [WIDTH-1:0] count_inc;

  // A rise on A and a fall on B in the same cycle collapse into one event.
  assign rise_a    = sig_a & ~a_d;
  assign fall_b    = ~sig_b & b_d;
  assign evt       = rise_a | fall_b;
  assign inc       = (state == ST_RUN) & evt;
  assign count_inc = count + WIDTH'(1);
  assign hit       = inc & (count_inc == LIMIT_V);

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (en) state_next = ST_RUN;
        ST_RUN: begin
          if (hit)      state_next = ST_DONE;
          else if (!en) state_next = ST_IDLE;
        end
        ST_DONE: state_next = ST_DONE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Edge-detect history keeps tracking through clear; reset preloads it so the
  // first cycle after release never sees an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_d <= 1'b1;
      b_d <= 1'b0;
    end else begin
      a_d <= sig_a;
      b_d <= sig_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else if (clear) begin
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (inc) begin
        count     <= count_inc;
        out_data  <= count_inc;
        out_valid <= 1'b1;
        if (out_valid && !out_ready) overrun <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (hit) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dual_edge_counter.sv
// Self-checking bench for dual_edge_counter: directed scenarios plus random
// stimulus, compared every cycle against a behavioural model of the counter.
module tb_dual_edge_counter;

  localparam int WIDTH = 5;
  localparam int LIMIT = 10;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             clear;
  logic             sig_a;
  logic             sig_b;
  logic             out_ready;
  logic [WIDTH-1:0] count;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             done;
  logic             overrun;

  dual_edge_counter #(.WIDTH(WIDTH), .LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear),
    .sig_a(sig_a), .sig_b(sig_b), .out_ready(out_ready),
    .count(count), .out_valid(out_valid), .out_data(out_data),
    .done(done), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Behavioural model: counting flag, finished flag, count and snapshot.
  int m_count, m_data;
  bit m_valid, m_done, m_ovr, m_run, pa, pb;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_update();
    bit ev, inc;
    if (!rst_n) begin
      m_count = 0; m_data = 0; m_valid = 0; m_done = 0; m_ovr = 0; m_run = 0;
      pa = 1; pb = 0;
    end else begin
      ev = (sig_a && !pa) || (!sig_b && pb);
      pa = sig_a;
      pb = sig_b;
      if (clear) begin
        m_count = 0; m_data = 0; m_valid = 0; m_done = 0; m_ovr = 0; m_run = 0;
      end else begin
        inc = m_run && ev;
        if (inc) begin
          m_count++;
          if (m_valid && !out_ready) m_ovr = 1;
          m_valid = 1;
          m_data = m_count;
        end else if (m_valid && out_ready) begin
          m_valid = 0;
        end
        if (!m_done) begin
          if (inc && m_count == LIMIT) begin
            m_done = 1;
            m_run = 0;
          end else begin
            m_run = en;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("count", int'(count), m_count);
    chk("out_valid", int'(out_valid), int'(m_valid));
    chk("out_data", int'(out_data), m_data);
    chk("done", int'(done), int'(m_done));
    chk("overrun", int'(overrun), int'(m_ovr));
  endtask

  task automatic step(input logic r, input logic c, input logic e,
                      input logic a, input logic b, input logic rd);
    rst_n = r; clear = c; en = e; sig_a = a; sig_b = b; out_ready = rd;
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  initial begin
    rst_n = 0; clear = 0; en = 0; sig_a = 0; sig_b = 0; out_ready = 0;
    @(negedge clk);

    step(0, 0, 1, 1, 0, 1);
    step(0, 0, 1, 1, 0, 1);
    chk("reset_count", int'(count), 0);
    chk("reset_valid", int'(out_valid), 0);

    // Release with sig_a high and sig_b low: no spurious event.
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 1, 0, 1);
      chk("release_no_event", int'(count), 0);
    end

    // Twelve rising edges: counts to LIMIT then holds.
    for (int k = 1; k <= 12; k++) begin
      step(1, 0, 1, 0, 0, 1);
      step(1, 0, 1, 1, 0, 1);
      chk("edge_count", int'(count), (k <= LIMIT) ? k : LIMIT);
    end
    chk("limit_count", int'(count), 10);
    chk("limit_done", int'(done), 1);

    // Clear from DONE, then restart counting.
    step(1, 1, 1, 1, 0, 1);
    chk("clear_count", int'(count), 0);
    chk("clear_done", int'(done), 0);
    chk("clear_overrun", int'(overrun), 0);
    step(1, 0, 1, 0, 0, 1);
    step(1, 0, 1, 1, 0, 1);
    chk("restart_count", int'(count), 1);

    // Simultaneous A rise and B fall count once.
    step(1, 0, 1, 0, 1, 1);
    step(1, 0, 1, 1, 0, 1);
    chk("simul_edges", int'(count), 2);

    // Three unconsumed increments then one acceptance.
    step(1, 1, 1, 1, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 1, 1, 0, 0);
      step(1, 0, 1, 0, 0, 0);
    end
    chk("ovr_valid", int'(out_valid), 1);
    chk("ovr_data", int'(out_data), 3);
    chk("ovr_flag", int'(overrun), 1);
    step(1, 0, 1, 0, 0, 1);
    chk("accept_valid", int'(out_valid), 0);
    chk("accept_overrun_sticky", int'(overrun), 1);

    // Reset mid-count discards everything.
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 1, 1, 0, 0);
      step(1, 0, 1, 0, 0, 0);
    end
    chk("pre_reset_count", int'(count), 6);
    chk("pre_reset_valid", int'(out_valid), 1);
    step(0, 0, 1, 1, 0, 0);
    chk("midrst_count", int'(count), 0);
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_data", int'(out_data), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_overrun", int'(overrun), 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(logic'($urandom_range(0, 199) != 0),
           logic'($urandom_range(0, 39) == 0),
           logic'($urandom_range(0, 7) != 0),
           logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
